// File: rtl/vector_mem_sequencer.sv
// Splits one VEC_W-bit vldr/vstr into BEATS word beats on the BUS_W memory port, stalling upstream.
// Optional per-beat ack timeout is built in when VMEM_TIMEOUT_EN is defined.
module vector_mem_sequencer #(
    parameter int unsigned VEC_W       = 128,
    parameter int unsigned BUS_W       = 32,
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              is_store,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [VEC_W-1:0]  wdata_vec,
    output logic              stall,
    output logic              done,
    output logic              err,
    output logic [VEC_W-1:0]  rdata_vec,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [BUS_W-1:0]  mem_wdata,
    input  logic [BUS_W-1:0]  mem_rdata,
    input  logic              mem_ack
);

    localparam int unsigned BEATS  = VEC_W / BUS_W;
    localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    if (BEATS == 0 || (VEC_W % BUS_W) != 0) begin : g_bad_width
        $error("VEC_W must be a nonzero multiple of BUS_W");
    end
    if (TIMEOUT_CYC < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYC must be at least 2");
    end

    typedef enum logic [1:0] {StIdle, StXfer, StDone} state_e;

    state_e              state_q;
    logic                store_q;
    logic [ADDR_W-1:0]   base_q;
    logic [VEC_W-1:0]    wdata_q;
    logic [BEAT_W-1:0]   beat_q;
    logic                err_q;
    logic                beat_ack;
    logic                timeout;

    assign beat_ack = (state_q == StXfer) && mem_ack;

`ifdef VMEM_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC);

    logic [CNT_W-1:0] wait_q;

    assign timeout = (state_q == StXfer) && !mem_ack && (wait_q == CNT_W'(TIMEOUT_CYC - 1));

    // Cleared outside XFER so every transfer starts its first beat with a fresh budget.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_q <= '0;
        end else if (state_q != StXfer || mem_ack) begin
            wait_q <= '0;
        end else begin
            wait_q <= wait_q + CNT_W'(1);
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            store_q   <= 1'b0;
            base_q    <= '0;
            wdata_q   <= '0;
            beat_q    <= '0;
            err_q     <= 1'b0;
            rdata_vec <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q <= StXfer;
                        store_q <= is_store;
                        base_q  <= base_addr;
                        wdata_q <= wdata_vec;
                        beat_q  <= '0;
                        err_q   <= 1'b0;
                    end
                end
                StXfer: begin
                    if (beat_ack) begin
                        if (!store_q) begin
                            rdata_vec[beat_q*BUS_W +: BUS_W] <= mem_rdata;
                        end
                        beat_q <= beat_q + BEAT_W'(1);
                        if (beat_q == LAST_BEAT) begin
                            state_q <= StDone;
                        end
                    end else if (timeout) begin
                        state_q <= StDone;
                        err_q   <= 1'b1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    err_q   <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign done      = (state_q == StDone);
    assign err       = done & err_q;
    assign mem_req   = (state_q == StXfer);
    assign mem_we    = mem_req & store_q;
    assign mem_addr  = mem_req ? (base_q + ADDR_W'(beat_q)) : '0;
    assign mem_wdata = mem_req ? wdata_q[beat_q*BUS_W +: BUS_W] : '0;
    // The issuing instruction must hold in the very cycle it raises start.
    assign stall     = mem_req | ((state_q == StIdle) & start & rst);

endmodule

// File: tb/tb_vector_mem_sequencer.sv
// Self-checking bench for vector_mem_sequencer: queue-based transfer model plus directed literals.
module tb_vector_mem_sequencer;

    localparam int unsigned VEC_W       = 128;
    localparam int unsigned BUS_W       = 32;
    localparam int unsigned ADDR_W      = 16;
    localparam int unsigned TIMEOUT_CYC = 64;
    localparam int unsigned BEATS       = VEC_W / BUS_W;

    logic              clk       = 1'b0;
    logic              rst       = 1'b0;
    logic              start     = 1'b0;
    logic              is_store  = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [VEC_W-1:0]  wdata_vec = '0;
    logic              stall;
    logic              done;
    logic              err;
    logic [VEC_W-1:0]  rdata_vec;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [BUS_W-1:0]  mem_wdata;
    logic [BUS_W-1:0]  mem_rdata = '0;
    logic              mem_ack   = 1'b0;

    vector_mem_sequencer #(
        .VEC_W      (VEC_W),
        .BUS_W      (BUS_W),
        .ADDR_W     (ADDR_W),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .is_store (is_store),
        .base_addr(base_addr),
        .wdata_vec(wdata_vec),
        .stall    (stall),
        .done     (done),
        .err      (err),
        .rdata_vec(rdata_vec),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ack  (mem_ack)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Transfer model: a pending transfer is just the list of beats still owed to memory.
    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic              we;
        logic [BUS_W-1:0]  wdata;
        int                idx;
    } beat_t;

    beat_t            pend[$];
    bit               done_due = 0;
    bit               err_due  = 0;
    int               wait_cnt = 0;
    logic [VEC_W-1:0] m_rdata  = '0;

    initial forever begin
        @(negedge clk);
        if (!rst) begin
            chk("rst_stall", stall, 0);
            chk("rst_done", done, 0);
            chk("rst_err", err, 0);
            chk("rst_req", mem_req, 0);
            chk("rst_we", mem_we, 0);
            chk("rst_addr", mem_addr, 0);
            chk("rst_wdata", mem_wdata, 0);
            chk("rst_rdata", rdata_vec, 0);
            pend.delete();
            done_due = 0;
            err_due  = 0;
            wait_cnt = 0;
            m_rdata  = '0;
        end else begin
            bit busy;
            bit idle;
            busy = (pend.size() != 0);
            idle = !busy && !done_due;
            chk("mdl_req", mem_req, busy);
            chk("mdl_stall", stall, busy || (idle && start));
            chk("mdl_done", done, done_due);
            chk("mdl_err", err, done_due && err_due);
            chk("mdl_rdata", rdata_vec, m_rdata);
            if (busy) begin
                chk("mdl_addr", mem_addr, pend[0].addr);
                chk("mdl_we", mem_we, pend[0].we);
                chk("mdl_wdata", mem_wdata, pend[0].wdata);
            end
            // Advance to the state after the coming rising edge; inputs are stable until then.
            if (done_due) begin
                done_due = 0;
                err_due  = 0;
            end else if (busy) begin
                if (mem_ack) begin
                    if (!pend[0].we) m_rdata[pend[0].idx*BUS_W +: BUS_W] = mem_rdata;
                    void'(pend.pop_front());
                    wait_cnt = 0;
                    if (pend.size() == 0) done_due = 1;
                end else begin
`ifdef VMEM_TIMEOUT_EN
                    wait_cnt++;
                    if (wait_cnt == TIMEOUT_CYC) begin
                        pend.delete();
                        done_due = 1;
                        err_due  = 1;
                    end
`endif
                end
            end else if (start) begin
                wait_cnt = 0;
                for (int k = 0; k < BEATS; k++) begin
                    beat_t b;
                    b.addr  = base_addr + ADDR_W'(k);
                    b.we    = is_store;
                    b.wdata = wdata_vec[k*BUS_W +: BUS_W];
                    b.idx   = k;
                    pend.push_back(b);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [BUS_W-1:0]  words[4]    = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    logic [ADDR_W-1:0] wrap_addr[4] = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};

    initial begin
        int ndone;
        int nreq;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) tick();

        // Load, ack always high: addresses on consecutive cycles, done at cycle 5.
        start = 1; is_store = 0; base_addr = 16'h0010; mem_ack = 1;
        @(negedge clk);
        chk("t1_stall_c0", stall, 1);
        for (int k = 0; k < 4; k++) begin
            tick();
            start = 0;
            mem_rdata = words[k];
            @(negedge clk);
            chk("t1_addr", mem_addr, 16'h0010 + k);
            chk("t1_stall", stall, 1);
        end
        tick();
        mem_ack = 0;
        @(negedge clk);
        chk("t1_done_c5", done, 1);
        chk("t1_stall_c5", stall, 0);
        chk("t1_rdata", rdata_vec, 128'h44444444_33333333_22222222_11111111);
        repeat (2) tick();

        // Store with ack every third cycle.
        start = 1; is_store = 1; base_addr = 16'h0100; mem_ack = 0;
        wdata_vec = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
        ndone = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            start = 0;
            mem_ack = (i % 3 == 2);
            @(negedge clk);
            if (i == 0) begin
                chk("t2_addr0", mem_addr, 16'h0100);
                chk("t2_wdata0", mem_wdata, 32'hAAAAAAAA);
                chk("t2_we0", mem_we, 1);
            end
            if (i == 11) begin
                chk("t2_addr3", mem_addr, 16'h0103);
                chk("t2_wdata3", mem_wdata, 32'hDDDDDDDD);
            end
            ndone += int'(done);
        end
        chk("t2_done_count", ndone, 1);
        mem_ack = 0;
        tick();

        // Address wrap at the top of the word space.
        start = 1; is_store = 0; base_addr = 16'hFFFE; mem_ack = 1;
        for (int k = 0; k < 4; k++) begin
            tick();
            start = 0;
            mem_rdata = $urandom;
            @(negedge clk);
            chk("t3_wrap_addr", mem_addr, wrap_addr[k]);
        end
        tick();
        mem_ack = 0;
        repeat (2) tick();

        // start held high through XFER and DONE: one transfer only.
        start = 1; is_store = 0; base_addr = 16'h0030; mem_ack = 1;
        nreq = 0;
        ndone = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            nreq += int'(mem_req);
            ndone += int'(done);
            tick();
            start = (i < 5);
        end
        chk("t4_req_cycles", nreq, 4);
        chk("t4_done_count", ndone, 1);
        mem_ack = 0;
        tick();

        // Asynchronous reset during beat 2 of a load.
        start = 1; is_store = 0; base_addr = 16'h0050; mem_ack = 1;
        tick();
        start = 0;
        tick();
        tick();
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("t5_async_req", mem_req, 0);
        chk("t5_async_stall", stall, 0);
        chk("t5_async_addr", mem_addr, 0);
        chk("t5_async_rdata", rdata_vec, 0);
        chk("t5_async_done", done, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        start = 1; base_addr = 16'h0060; mem_ack = 1;
        tick();
        start = 0;
        @(negedge clk);
        chk("t5_restart_beat0", mem_addr, 16'h0060);
        repeat (4) tick();
        @(negedge clk);
        chk("t5_restart_done", done, 1);
        mem_ack = 0;
        repeat (2) tick();

`ifdef VMEM_TIMEOUT_EN
        // Ack stuck low from beat 1: abort TIMEOUT_CYC cycles after beat 1 is first requested.
        begin
            int cyc;
            bit got;
            start = 1; is_store = 0; base_addr = 16'h0070; mem_ack = 1;
            tick();
            start = 0;
            tick();
            mem_ack = 0;
            cyc = 2;
            got = 0;
            for (int i = 0; i < 200 && !got; i++) begin
                @(negedge clk);
                if (done) begin
                    got = 1;
                    chk("to_cycle", cyc, 2 + TIMEOUT_CYC);
                    chk("to_err", err, 1);
                end else begin
                    tick();
                    cyc++;
                end
            end
            chk("to_done_seen", got, 1);
            tick();
            @(negedge clk);
            chk("to_idle_req", mem_req, 0);
            tick();
        end
`endif

        // Randomized traffic against the model.
        for (int n = 0; n < 1500; n++) begin
            start     = ($urandom_range(0, 3) == 0);
            is_store  = 1'($urandom_range(0, 1));
            base_addr = ADDR_W'($urandom);
            wdata_vec = {$urandom, $urandom, $urandom, $urandom};
            mem_ack   = ($urandom_range(0, 2) != 0);
            mem_rdata = $urandom;
            tick();
        end
        start = 0;
        mem_ack = 1;
        repeat (8) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
